// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, stall hold buffer and branch redirect.
// Optional memory-wait counter enabled by defining FETCH_STALL_COUNT_EN.
module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic        imem_read,
    output logic [15:0] imem_address,
    output logic [15:0] IR_out,
    output logic [15:0] PC_out,
    output logic        load_latch,
    output logic        inject_NOP,
    output logic [15:0] fetch_stall_count
);
    localparam logic [1:0] S_REQ     = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]  state;
    logic [15:0] pc, hold_buf, redir;
    logic [15:0] pc_plus2, tgt;

    assign pc_plus2 = pc + 16'd2;
    assign tgt      = branch_target & 16'hFFFE;

    always_comb begin
        imem_address = pc;
        imem_read    = (state != S_HOLD);
        load_latch   = !stall;
        PC_out       = pc_plus2;
        IR_out       = (state == S_HOLD) ? hold_buf : imem_rdata;
        inject_NOP   = 1'b1;
        if (state == S_REQ && imem_resp && !branch_taken)
            inject_NOP = 1'b0;
        if (state == S_HOLD && !branch_taken)
            inject_NOP = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= 16'h0000;
            hold_buf <= 16'h0000;
            redir    <= 16'h0000;
        end else begin
            case (state)
                S_REQ: begin
                    if (branch_taken) begin
                        // Without a response the request is still in flight, so the
                        // address must stay put until the stale data is swallowed.
                        if (imem_resp) begin
                            pc <= tgt;
                        end else begin
                            redir <= tgt;
                            state <= S_DISCARD;
                        end
                    end else if (imem_resp) begin
                        if (stall) begin
                            hold_buf <= imem_rdata;
                            state    <= S_HOLD;
                        end else begin
                            pc <= pc_plus2;
                        end
                    end
                end
                S_HOLD: begin
                    if (branch_taken) begin
                        pc    <= tgt;
                        state <= S_REQ;
                    end else if (!stall) begin
                        pc    <= pc_plus2;
                        state <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (branch_taken)
                        redir <= tgt;
                    if (imem_resp) begin
                        pc    <= branch_taken ? tgt : redir;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= 16'h0000;
        else if (imem_read && !imem_resp && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign fetch_stall_count = stall_cnt;
`else
    assign fetch_stall_count = 16'h0000;
`endif

endmodule
